// File: rtl/uart_pkg.sv
// Shared UART constants: default oversample ratio and 50 MHz divisor values
// (clocks per oversample tick minus one, x16 oversampling).
package uart_pkg;

    typedef logic [15:0] baud_div_t;

    localparam int        OVERSAMPLE_DEF = 16;
    localparam baud_div_t DIV_9600       = 16'd324;
    localparam baud_div_t DIV_57600      = 16'd53;
    localparam baud_div_t DIV_115200     = 16'd26;

endpackage

// File: rtl/mod_counter.sv
// Count-to-terminal counter: wraps to zero after reaching max_val while enabled,
// with synchronous clear and load. tc flags the terminal value.
module mod_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic [W-1:0] max_val,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_r;

    assign cnt = cnt_r;
    assign tc  = (cnt_r == max_val);

    // Counter register: clear beats load beats counting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {W{1'b0}};
        end else if (clr) begin
            cnt_r <= {W{1'b0}};
        end else if (ld) begin
            cnt_r <= ld_val;
        end else if (en && tc) begin
            cnt_r <= {W{1'b0}};
        end else if (en) begin
            cnt_r <= cnt_r + W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/baud_tick_gen.sv
// Programmable baud generator: oversample strobe, bit strobe and a 50 % duty
// bit-rate square wave, with glitch-free divisor reload and mid-bit restart.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DIV_RESET  = int'(DIV_115200)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div_in,
    input  logic             div_wr,
    input  logic             restart,
    output logic             div_busy,
    output logic             tick_os,
    output logic             tick_baud,
    output logic             clk_baud
);

    localparam int              OS_W     = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_HALF  = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0] OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);

    logic [DIV_W-1:0] div_act_r, div_act_n;
    logic [DIV_W-1:0] div_pend_r, div_pend_n;
    logic             pend_r, pend_n;
    logic             tick_os_r, tick_os_n;
    logic             tick_baud_r, tick_baud_n;
    logic             clk_baud_r, clk_baud_n;

    logic [DIV_W-1:0] div_cnt_s;
    logic             div_tc_s;
    logic [OS_W-1:0]  os_cnt_s;
    logic             os_tc_s;
    logic             term_s;
    logic             idle_apply_s;
    logic             div_clr_s;
    logic             apply_s;

    assign term_s       = en & div_tc_s;
    assign idle_apply_s = ~restart & ~en & pend_r;
    // A smaller divisor applied while idle restarts the period so the counter
    // can never sit above the active divisor.
    assign div_clr_s    = restart | (idle_apply_s & (div_pend_r < div_cnt_s));

    mod_counter #(.W(DIV_W)) u_div_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .clr     (div_clr_s),
        .ld      (1'b0),
        .ld_val  ({DIV_W{1'b0}}),
        .max_val (div_act_r),
        .cnt     (div_cnt_s),
        .tc      (div_tc_s)
    );

    mod_counter #(.W(OS_W)) u_os_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (term_s),
        .clr     (1'b0),
        .ld      (restart),
        .ld_val  (OS_HALF),
        .max_val (OS_LAST),
        .cnt     (os_cnt_s),
        .tc      (os_tc_s)
    );

    // Next-state: restart outranks terminal count, which outranks the capture.
    always_comb begin
        div_act_n   = div_act_r;
        div_pend_n  = div_pend_r;
        pend_n      = pend_r;
        tick_os_n   = 1'b0;
        tick_baud_n = 1'b0;
        clk_baud_n  = clk_baud_r;
        apply_s     = 1'b0;
        if (restart) begin
            clk_baud_n = 1'b1;
            apply_s    = pend_r;
        end else if (term_s) begin
            tick_os_n   = 1'b1;
            tick_baud_n = os_tc_s;
            clk_baud_n  = (os_tc_s || (os_cnt_s == OS_MID)) ? ~clk_baud_r : clk_baud_r;
            apply_s     = pend_r;
        end else begin
            apply_s = idle_apply_s;
        end
        if (apply_s) begin
            div_act_n = div_pend_r;
            pend_n    = 1'b0;
        end else begin
            div_act_n = div_act_r;
        end
        // A same-cycle write is always left pending, even across restart.
        if (div_wr) begin
            div_pend_n = div_in;
            pend_n     = 1'b1;
        end else begin
            div_pend_n = div_pend_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_act_r   <= DIV_W'(DIV_RESET);
            div_pend_r  <= {DIV_W{1'b0}};
            pend_r      <= 1'b0;
            tick_os_r   <= 1'b0;
            tick_baud_r <= 1'b0;
            clk_baud_r  <= 1'b0;
        end else begin
            div_act_r   <= div_act_n;
            div_pend_r  <= div_pend_n;
            pend_r      <= pend_n;
            tick_os_r   <= tick_os_n;
            tick_baud_r <= tick_baud_n;
            clk_baud_r  <= clk_baud_n;
        end
    end

    assign div_busy  = pend_r;
    assign tick_os   = tick_os_r;
    assign tick_baud = tick_baud_r;
    assign clk_baud  = clk_baud_r;

endmodule

// File: doc/baud_tick_gen.md
# baud_tick_gen

Parametrised, runtime-programmable baud-rate generator for the UART path. It produces a one-cycle oversample strobe for the receiver, a one-cycle bit strobe for the transmitter, and a 50 % duty `clk_baud` square wave for legacy consumers. The divisor is reloadable without glitches, and phase can be realigned to a detected start bit. It sits between the system clock and the UART TX/RX blocks and replaces the fixed 115200-baud divider.

## Interface
- `DIV_W`, 16: width of the divisor and its counter.
- `OVERSAMPLE`, 16: oversample ticks per bit; even, ≥ 2.
- `DIV_RESET`, 26: divisor after reset. 50 MHz / (115200·16) ≈ 27 clocks, minus 1.

Ports:
- `clk`, in, 1: system clock (50 MHz).
- `rst_n`, in, 1: synchronous reset, active-low. Sampled on the rising edge of `clk`.
- `en`, in, 1: count enable. When low, all counters and `clk_baud` hold.
- `div_in`, in, `DIV_W`: new divisor value, equal to clocks per oversample tick minus 1.
- `div_wr`, in, 1: one-cycle strobe that captures `div_in`.
- `restart`, in, 1: one-cycle strobe that realigns phase to mid-bit.
- `div_busy`, out, 1: a captured divisor is pending and not yet applied.
- `tick_os`, out, 1: one-cycle oversample strobe.
- `tick_baud`, out, 1: one-cycle bit strobe.
- `clk_baud`, out, 1: square wave with period of one bit time.

## Operation
- Registers:
  - `div_act`: active divisor.
  - `div_cnt` (`DIV_W`).
  - `os_cnt` (width clog2(OVERSAMPLE)).
  - `div_pend` plus `pend` flag.
- Reset values: `div_act`=`DIV_RESET`, `div_cnt`=0, `os_cnt`=0, `pend`=0, `tick_os`=0, `tick_baud`=0, `clk_baud`=0, `div_busy`=0.
- Divider, in each cycle with `en`=1:
  - If `div_cnt`==`div_act`: `div_cnt`←0 and `tick_os`←1.
  - Otherwise: `div_cnt`+1 and `tick_os`←0.
  - With `en`=0, `tick_os` and `tick_baud` are 0.
- Terminal-count event = `en` & (`div_cnt`==`div_act`). On each terminal-count event:
  - `os_cnt` advances modulo OVERSAMPLE.
  - On the wrap OVERSAMPLE-1→0, `tick_baud`←1 in the same cycle as `tick_os`.
  - `clk_baud` toggles when `os_cnt` is OVERSAMPLE/2-1 or OVERSAMPLE-1.
- Divisor reload:
  - `div_wr` captures `div_in` into `div_pend` and sets `pend`.
  - The pending value is copied to `div_act` on the next terminal-count event, or on the next cycle if `en`=0. `pend` then clears.
  - A second `div_wr` while pending overwrites `div_pend`; the last write wins.
  - `div_in`=0 is legal and gives `tick_os` every clock.
- Restart:
  - `restart` sets `div_cnt`←0, `os_cnt`←OVERSAMPLE/2, `clk_baud`←1, and applies any pending divisor immediately.
  - Effect: the first `tick_baud` lands mid-bit for RX sampling.
- Priority: `rst_n` > `restart` > terminal-count event > `div_wr` capture.
- A `div_wr` in the same cycle as `restart` is captured as pending. It is not applied by that `restart`.
- No arithmetic overflow is possible: `div_cnt` never exceeds `div_act`.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- `tick_os` period is exactly `div_act`+1 cycles.
- `tick_baud` period is (`div_act`+1)·OVERSAMPLE cycles.
- `clk_baud` is high for half of that period and low for the other half.
- With `en` high from the first cycle after reset release, the first `tick_os` is asserted D+1 cycles later, where D=`div_act`.
- Divisor reload: the new divisor governs the period that starts immediately after the terminal count at which it is applied. No tick period is ever shortened below min(old, new)+1.
- `div_busy` rises the cycle after `div_wr` and falls the cycle after the value is applied.
- Restart: the first `tick_os` comes `div_act`+1 cycles after `restart`. The first `tick_baud` comes after OVERSAMPLE/2 `tick_os` pulses.
- Reset mid-period: state returns to reset values on the next edge. No tick is emitted in the reset cycle.

## Structure
- Package `uart_pkg` holds:
  - `OVERSAMPLE_DEF`=16.
  - Divisor constants `DIV_9600`=324, `DIV_57600`=53, `DIV_115200`=26 (50 MHz, ×16).
  - typedef `baud_div_t` (logic [15:0]).
- One sub-module is natural: `mod_counter` (`DIV_W`-wide count-to-terminal with enable, synchronous clear, and a terminal flag). It is instantiated for `div_cnt`, with a second narrow instance for `os_cnt`.

## Test plan
- Default rate: reset, then `en`=1 → `tick_os` every 27 cycles, `tick_baud` every 432 cycles, `clk_baud` high for 216 cycles and low for 216.
- Reload: `div_wr` with `div_in`=53 mid-period → the current period completes at 27 cycles, subsequent `tick_os` every 54 cycles, `div_busy` high for the gap.
- Zero divisor: `div_in`=0 with `en`=0, then `en`=1 → `tick_os` every cycle, `tick_baud` every 16 cycles.
- Restart: `restart` pulse → `tick_os` 27 cycles later, first `tick_baud` after 8 `tick_os` pulses (216 cycles), `clk_baud`=1 the cycle after the pulse.
- Enable gating: drop `en` for 10 cycles mid-count → tick positions are shifted by exactly 10 cycles, no ticks during the gap, `clk_baud` frozen.
- Reset mid-operation: assert `rst_n`=0 for 1 cycle at `div_cnt`=15 → all outputs 0 and the next `tick_os` comes 27 cycles after release.
